// File: rtl/copytoken_dispatcher_if.sv
// Handshake bundle between parser channels, the replay path and the dispatcher output.
// master = surrounding logic, slave = copytoken_dispatcher.
interface copytoken_dispatcher_if #(
    parameter int unsigned NUM_PARSER = 6,
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned BV_W       = 8,
    parameter int unsigned OFF_W      = 16
);
    localparam int unsigned TW = ADDR_W + BV_W + OFF_W;

    logic [TW*NUM_PARSER-1:0] req_token;
    logic [NUM_PARSER-1:0]    req_valid;
    logic [NUM_PARSER-1:0]    req_ready;
    logic [TW-1:0]            unsolved_token;
    logic                     unsolved_valid;
    logic                     unsolved_ready;
    logic [ADDR_W-1:0]        out_addr;
    logic [BV_W-1:0]          out_bvalid;
    logic [OFF_W-1:0]         out_offset;
    logic                     out_src;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output req_token, req_valid, unsolved_token, unsolved_valid, out_ready,
        input  req_ready, unsolved_ready, out_addr, out_bvalid, out_offset, out_src, out_valid
    );

    modport slave (
        input  req_token, req_valid, unsolved_token, unsolved_valid, out_ready,
        output req_ready, unsolved_ready, out_addr, out_bvalid, out_offset, out_src, out_valid
    );
endinterface

// File: rtl/copytoken_dispatcher.sv
// Merges round-robin parser copy-tokens with replayed unsolved tokens into one registered output.
// Optional statistics counters are built when COPYTOKEN_DISPATCHER_STATS_EN is defined.
module copytoken_dispatcher #(
    parameter int unsigned NUM_PARSER = 6,
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned BV_W       = 8,
    parameter int unsigned OFF_W      = 16,
    parameter int unsigned RQ_DEPTH   = 8,
    parameter int unsigned REPLAY_HI  = 6,
    parameter int unsigned STARVE_MAX = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    copytoken_dispatcher_if.slave      bus,
    output logic [$clog2(RQ_DEPTH):0]  replay_level,
    output logic [31:0]                stat_parser,
    output logic [31:0]                stat_replay,
    output logic [31:0]                stat_stall
);
    localparam int unsigned TW = ADDR_W + BV_W + OFF_W;
    localparam int unsigned PW = $clog2(NUM_PARSER);
    localparam int unsigned AW = $clog2(RQ_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    logic [TW-1:0]         mem_q [RQ_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic [PW-1:0]         last_grant_q, last_grant_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_src_q, out_src_d;
    logic [TW-1:0]         out_tok_q, out_tok_d;

    logic [TW-1:0]         req_tok [NUM_PARSER];
    logic                  slot_free, any_req, use_replay, grant_en, found, pop, push;
    logic [PW-1:0]         grant_idx;
    int unsigned           rr_idx;

    always_comb begin
        for (int unsigned i = 0; i < NUM_PARSER; i++) begin
            req_tok[i] = bus.req_token[TW*i +: TW];
        end
    end

    // Round-robin search starting just after the last parser granted
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        rr_idx    = 0;
        for (int unsigned k = 1; k <= NUM_PARSER; k++) begin
            rr_idx = (32'(last_grant_q) + k) % NUM_PARSER;
            if (!found && bus.req_valid[PW'(rr_idx)]) begin
                found     = 1'b1;
                grant_idx = PW'(rr_idx);
            end
        end
    end

    always_comb begin
        slot_free  = !out_valid_q || bus.out_ready;
        any_req    = |bus.req_valid;
        use_replay = rst_n && slot_free && (level_q != '0) &&
                     ((level_q >= LW'(REPLAY_HI)) || (starve_q == SW'(STARVE_MAX)) || !any_req);
        grant_en   = rst_n && slot_free && !use_replay && found;
        pop        = use_replay;
        bus.req_ready      = grant_en ? (NUM_PARSER'(1) << grant_idx) : '0;
        bus.unsolved_ready = rst_n && (level_q != LW'(RQ_DEPTH));
        push       = bus.unsolved_valid && bus.unsolved_ready;
    end

    // Next-state for the output slot, FIFO pointers and starvation counter
    always_comb begin
        out_valid_d  = out_valid_q;
        out_src_d    = out_src_q;
        out_tok_d    = out_tok_q;
        last_grant_d = last_grant_q;
        if (use_replay) begin
            out_valid_d = 1'b1;
            out_src_d   = 1'b1;
            out_tok_d   = mem_q[rd_ptr_q];
        end else if (grant_en) begin
            out_valid_d  = 1'b1;
            out_src_d    = 1'b0;
            out_tok_d    = req_tok[grant_idx];
            last_grant_d = grant_idx;
        end else if (slot_free) begin
            out_valid_d = 1'b0;
        end
        rd_ptr_d = rd_ptr_q + AW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push);
        level_d  = level_q + LW'(push) - LW'(pop);
        if (pop || (level_q == '0)) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_src_q    <= 1'b0;
            out_tok_q    <= '0;
            last_grant_q <= PW'(NUM_PARSER - 1);
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            level_q      <= '0;
            starve_q     <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_src_q    <= out_src_d;
            out_tok_q    <= out_tok_d;
            last_grant_q <= last_grant_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            level_q      <= level_d;
            starve_q     <= starve_d;
        end
    end

    // Storage needs no reset: pointers define which entries are live
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.unsolved_token;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_src    = out_src_q;
    assign bus.out_addr   = out_tok_q[TW-1 -: ADDR_W];
    assign bus.out_bvalid = out_tok_q[OFF_W +: BV_W];
    assign bus.out_offset = out_tok_q[OFF_W-1:0];
    assign replay_level   = level_q;

`ifdef COPYTOKEN_DISPATCHER_STATS_EN
    logic [31:0] stat_parser_q, stat_parser_d;
    logic [31:0] stat_replay_q, stat_replay_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_parser_d = stat_parser_q + 32'(grant_en);
        stat_replay_d = stat_replay_q + 32'(pop);
        stat_stall_d  = stat_stall_q + 32'(out_valid_q && !bus.out_ready);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_parser_q <= '0;
            stat_replay_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_parser_q <= stat_parser_d;
            stat_replay_q <= stat_replay_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_parser = stat_parser_q;
    assign stat_replay = stat_replay_q;
    assign stat_stall  = stat_stall_q;
`else
    assign stat_parser = '0;
    assign stat_replay = '0;
    assign stat_stall  = '0;
`endif
endmodule

// File: tb/tb_copytoken_dispatcher.sv
// Self-checking bench for copytoken_dispatcher: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_copytoken_dispatcher;
    localparam int NP = 6, AWD = 9, BW = 8, OW = 16, TW = 33;
    localparam int DEPTH = 8, HI = 6, SMAX = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  replay_level;
    logic [31:0] stat_parser, stat_replay, stat_stall;

    copytoken_dispatcher_if #(.NUM_PARSER(NP), .ADDR_W(AWD), .BV_W(BW), .OFF_W(OW)) bus();

    copytoken_dispatcher #(
        .NUM_PARSER(NP), .ADDR_W(AWD), .BV_W(BW), .OFF_W(OW),
        .RQ_DEPTH(DEPTH), .REPLAY_HI(HI), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .replay_level(replay_level),
        .stat_parser(stat_parser), .stat_replay(stat_replay), .stat_stall(stat_stall)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [TW-1:0] q[$];
    bit            m_valid, m_src, m_rst;
    logic [TW-1:0] m_tok;
    int            last_g, starve;
    int unsigned   st_p, st_r, st_s;
    int            n_checks = 0, n_fail = 0;

    typedef struct {
        logic [5:0] rv;
        logic       ordy;
        logic [5:0] exp_rr;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        q.delete();
        m_valid = 0; m_src = 0; m_tok = '0; m_rst = 1;
        last_g = NP - 1; starve = 0;
        st_p = 0; st_r = 0; st_s = 0;
    endtask

    task automatic rand_tokens();
        for (int i = 0; i < NP; i++) bus.req_token[i*TW +: TW] = TW'({$urandom, $urandom});
        bus.unsolved_token = TW'({$urandom, $urandom});
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0; bus.unsolved_valid = 1'b0; bus.out_ready = 1'b0;
        rand_tokens();
    endtask

    // One clock: compare DUT against the model, advance the model, move to the next negedge
    task automatic cycle();
        int lvl, g, idx;
        bit sf, use_rep, push;
        logic [5:0] exp_rr;
        bit exp_ur;
        #1;
        lvl = q.size();
        chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
        if (m_valid || m_rst) begin
            chk("out_addr",   64'(bus.out_addr),   64'(m_tok[32:24]));
            chk("out_bvalid", 64'(bus.out_bvalid), 64'(m_tok[23:16]));
            chk("out_offset", 64'(bus.out_offset), 64'(m_tok[15:0]));
            chk("out_src",    64'(bus.out_src),    64'(m_src));
        end
        chk("replay_level", 64'(replay_level), 64'(lvl));
`ifdef COPYTOKEN_DISPATCHER_STATS_EN
        chk("stat_parser", 64'(stat_parser), 64'(st_p));
        chk("stat_replay", 64'(stat_replay), 64'(st_r));
        chk("stat_stall",  64'(stat_stall),  64'(st_s));
`else
        chk("stat_tied", 64'({stat_parser, stat_replay} | 64'(stat_stall)), 64'd0);
`endif
        sf = 0; use_rep = 0; g = -1;
        if (!rst_n) begin
            exp_rr = '0; exp_ur = 0;
        end else begin
            sf = !m_valid || bus.out_ready;
            use_rep = sf && lvl > 0 && (lvl >= HI || starve == SMAX || bus.req_valid == '0);
            if (sf && !use_rep) begin
                for (int k = 1; k <= NP; k++) begin
                    idx = (last_g + k) % NP;
                    if (g < 0 && bus.req_valid[idx]) g = idx;
                end
            end
            exp_rr = (g >= 0) ? 6'(1 << g) : 6'd0;
            exp_ur = lvl < DEPTH;
        end
        chk("req_ready", 64'(bus.req_ready), 64'(exp_rr));
        chk("unsolved_ready", 64'(bus.unsolved_ready), 64'(exp_ur));
        if (!rst_n) begin
            reset_model();
        end else begin
            if (m_valid && !bus.out_ready) st_s++;
            push = bus.unsolved_valid && lvl < DEPTH;
            if (use_rep) begin
                m_tok = q.pop_front(); m_valid = 1; m_src = 1; m_rst = 0; st_r++;
            end else if (g >= 0) begin
                m_tok = bus.req_token[g*TW +: TW]; m_valid = 1; m_src = 0; m_rst = 0;
                last_g = g; st_p++;
            end else if (sf) begin
                m_valid = 0; m_rst = 0;
            end
            if (use_rep || lvl == 0) starve = 0;
            else if (starve < SMAX) starve++;
            if (push) q.push_back(bus.unsolved_token);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic hard_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
    endtask

    initial begin
        int n;
        logic [TW-1:0] tok;
        tbl[0]  = '{6'b100101, 1'b1, 6'b000001};
        tbl[1]  = '{6'b100101, 1'b1, 6'b000100};
        tbl[2]  = '{6'b100101, 1'b1, 6'b100000};
        tbl[3]  = '{6'b100101, 1'b1, 6'b000001};
        tbl[4]  = '{6'b000010, 1'b1, 6'b000010};
        tbl[5]  = '{6'b000010, 1'b0, 6'b000000};
        tbl[6]  = '{6'b000010, 1'b0, 6'b000000};
        tbl[7]  = '{6'b000010, 1'b0, 6'b000000};
        tbl[8]  = '{6'b000010, 1'b0, 6'b000000};
        tbl[9]  = '{6'b000010, 1'b1, 6'b000010};
        tbl[10] = '{6'b111111, 1'b1, 6'b000100};
        tbl[11] = '{6'b110000, 1'b1, 6'b010000};
        tbl[12] = '{6'b000000, 1'b1, 6'b000000};

        @(negedge clk);
        hard_reset();
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset level", 64'(replay_level), 64'd0);

        // Round-robin, stall and hold behaviour from the vector table
        foreach (tbl[i]) begin
            rand_tokens();
            bus.req_valid = tbl[i].rv; bus.out_ready = tbl[i].ordy; bus.unsolved_valid = 1'b0;
            #1;
            chk($sformatf("table[%0d] req_ready", i), 64'(bus.req_ready), 64'(tbl[i].exp_rr));
            cycle();
        end
`ifdef COPYTOKEN_DISPATCHER_STATS_EN
        chk("table stat_stall", 64'(stat_stall), 64'd4);
`endif

        // Replay priority once the FIFO reaches the high mark
        hard_reset();
        bus.req_valid = '1; bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_tokens(); bus.unsolved_valid = 1'b1; cycle();
        end
        bus.unsolved_valid = 1'b0; rand_tokens();
        #1;
        chk("hi level", 64'(replay_level), 64'd6);
        chk("hi req_ready", 64'(bus.req_ready), 64'd0);
        cycle();
        chk("hi out_src", 64'(bus.out_src), 64'd1);
        rand_tokens(); cycle();
        chk("below hi out_src", 64'(bus.out_src), 64'd0);

        // Starvation: single token popped 16 cycles after its push
        hard_reset();
        bus.req_valid = '1; bus.out_ready = 1'b1; bus.unsolved_valid = 1'b1;
        tok = bus.unsolved_token;
        cycle();
        bus.unsolved_valid = 1'b0;
        n = 0;
        while (n < 40) begin
            rand_tokens(); cycle(); n++;
            if (bus.out_valid && bus.out_src) break;
        end
        chk("starve pop delay", 64'(n), 64'd16);
        chk("starve token", 64'({bus.out_addr, bus.out_bvalid, bus.out_offset}), 64'(tok));

        // Full FIFO: ready low even while popping; push+pop holds level
        hard_reset();
        bus.req_valid = 6'b000001; cycle();
        bus.req_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rand_tokens(); bus.unsolved_valid = 1'b1; cycle();
        end
        #1;
        chk("full level", 64'(replay_level), 64'd8);
        chk("full unsolved_ready", 64'(bus.unsolved_ready), 64'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("full pop unsolved_ready", 64'(bus.unsolved_ready), 64'd0);
        cycle();
        chk("after full pop level", 64'(replay_level), 64'd7);
        rand_tokens();
        #1;
        chk("pushpop unsolved_ready", 64'(bus.unsolved_ready), 64'd1);
        cycle();
        chk("pushpop level", 64'(replay_level), 64'd7);

        // Reset mid-operation discards output and FIFO
        hard_reset();
        bus.req_valid = 6'b000001; cycle();
        bus.req_valid = '1;
        for (int i = 0; i < 5; i++) begin
            rand_tokens(); bus.unsolved_valid = 1'b1; cycle();
        end
        bus.unsolved_valid = 1'b0;
        chk("pre-reset level", 64'(replay_level), 64'd5);
        chk("pre-reset out_valid", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0; bus.unsolved_valid = 1'b1;
        #1;
        chk("in-reset req_ready", 64'(bus.req_ready), 64'd0);
        chk("in-reset unsolved_ready", 64'(bus.unsolved_ready), 64'd0);
        cycle();
        rst_n = 1'b1; bus.unsolved_valid = 1'b0; bus.out_ready = 1'b1;
        chk("post-reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("post-reset level", 64'(replay_level), 64'd0);
        #1;
        chk("post-reset first grant", 64'(bus.req_ready), 64'd1);
        cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rand_tokens();
            bus.req_valid      = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
            bus.out_ready      = ($urandom_range(0, 3) != 0);
            bus.unsolved_valid = ($urandom_range(0, 9) < 4);
            rst_n              = ($urandom_range(0, 299) != 0);
            cycle();
        end
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
